// File: rtl/div_hilo_ctrl.sv
// Sequencing controller between the execute stage and the iterative divider.
// Issues the divider start pulse, tracks completion and owns the HI/LO registers.
module div_hilo_ctrl #(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        req_valid,
    input  logic        req_signed,
    input  logic [31:0] req_x,
    input  logic [31:0] req_y,
    output logic        req_ready,
    input  logic        flush,
    input  logic        mthi_we,
    input  logic        mtlo_we,
    input  logic [31:0] mt_data,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        busy,
    output logic        done,
    output logic        timeout_err,
    output logic        div_start,
    output logic        div_signed,
    output logic [31:0] div_x,
    output logic [31:0] div_y,
    input  logic        div_complete,
    input  logic [31:0] div_s,
    input  logic [31:0] div_r
);

    // state   | meaning
    // S_IDLE  | no division in flight, requests accepted
    // S_START | start pulse to the divider this cycle
    // S_WAIT  | waiting for div_complete, timeout counter running
    // S_WB    | result captured, HI/LO written at the end of this cycle
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_WAIT  = 2'd2,
        S_WB    = 2'd3
    } state_t;

    localparam logic [4:0] WAIT_TC = 5'(TIMEOUT - 1);

    state_t      state;
    logic [4:0]  wait_cnt;
    logic [31:0] res_s;
    logic [31:0] res_r;
    logic        accept;
    logic        abort;

    assign req_ready = (state == S_IDLE) & ~flush & ~mthi_we & ~mtlo_we;
    assign accept    = req_valid & req_ready;
    // An MT write while busy cancels the division just like a flush.
    assign abort     = (state != S_IDLE) & (flush | mthi_we | mtlo_we);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state       <= S_IDLE;
            wait_cnt    <= '0;
            res_s       <= '0;
            res_r       <= '0;
            hi          <= '0;
            lo          <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            timeout_err <= 1'b0;
            div_start   <= 1'b0;
            div_signed  <= 1'b0;
            div_x       <= '0;
            div_y       <= '0;
        end else begin
            div_start <= 1'b0;
            done      <= 1'b0;
            if (mthi_we) hi <= mt_data;
            if (mtlo_we) lo <= mt_data;

            case (state)
                S_IDLE: begin
                    if (accept) begin
                        div_signed <= req_signed;
                        div_x      <= req_x;
                        div_y      <= req_y;
                        div_start  <= 1'b1;
                        busy       <= 1'b1;
                        state      <= S_START;
                    end
                end
                S_START: begin
                    wait_cnt <= '0;
                    if (abort) begin
                        busy  <= 1'b0;
                        state <= S_IDLE;
                    end else begin
                        state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    wait_cnt <= wait_cnt + 5'd1;
                    if (abort) begin
                        busy  <= 1'b0;
                        state <= S_IDLE;
                    end else if (div_complete) begin
                        // Capture here so writeback does not depend on the divider holding its outputs.
                        res_s <= div_s;
                        res_r <= div_r;
                        state <= S_WB;
                    end else if (wait_cnt + 5'd1 == WAIT_TC) begin
                        timeout_err <= 1'b1;
                        busy        <= 1'b0;
                        state       <= S_IDLE;
                    end
                end
                S_WB: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                    if (!abort) begin
                        hi   <= res_r;
                        lo   <= res_s;
                        done <= 1'b1;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_div_hilo_ctrl.sv
// Directed bench for div_hilo_ctrl with a behavioural 10-cycle divider model.
// Expected HI/LO values are hand-computed constants.
module tb_div_hilo_ctrl;

    logic        clk;
    logic        resetn;
    logic        req_valid;
    logic        req_signed;
    logic [31:0] req_x;
    logic [31:0] req_y;
    logic        req_ready;
    logic        flush;
    logic        mthi_we;
    logic        mtlo_we;
    logic [31:0] mt_data;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        busy;
    logic        done;
    logic        timeout_err;
    logic        div_start;
    logic        div_signed;
    logic [31:0] div_x;
    logic [31:0] div_y;
    logic        div_complete;
    logic [31:0] div_s;
    logic [31:0] div_r;

    int checks = 0;
    int errors = 0;

    div_hilo_ctrl #(.TIMEOUT(16)) dut (
        .clk(clk), .resetn(resetn),
        .req_valid(req_valid), .req_signed(req_signed), .req_x(req_x), .req_y(req_y),
        .req_ready(req_ready), .flush(flush),
        .mthi_we(mthi_we), .mtlo_we(mtlo_we), .mt_data(mt_data),
        .hi(hi), .lo(lo), .busy(busy), .done(done), .timeout_err(timeout_err),
        .div_start(div_start), .div_signed(div_signed), .div_x(div_x), .div_y(div_y),
        .div_complete(div_complete), .div_s(div_s), .div_r(div_r)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Divider model: operands latched on start, completion pulse 10 cycles later.
    logic        m_en;
    int          m_cnt;
    logic [31:0] m_s;
    logic [31:0] m_r;

    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            m_cnt <= 0;
            m_s   <= '0;
            m_r   <= '0;
        end else if (div_start) begin
            m_cnt <= 10;
            if (div_y == 32'd0) begin
                m_s <= 32'hFFFF_FFFF;
                m_r <= div_x;
            end else if (div_signed) begin
                m_s <= $signed(div_x) / $signed(div_y);
                m_r <= $signed(div_x) % $signed(div_y);
            end else begin
                m_s <= div_x / div_y;
                m_r <= div_x % div_y;
            end
        end else if (m_cnt != 0) begin
            m_cnt <= m_cnt - 1;
        end
    end

    assign div_complete = m_en && (m_cnt == 1);
    assign div_s = m_s;
    assign div_r = m_r;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drives one request and waits for done (bounded); leaves the bench in the done cycle.
    task automatic run_div(input logic sgn, input logic [31:0] x, input logic [31:0] y,
                           output bit ok);
        ok = 1'b0;
        req_signed = sgn;
        req_x      = x;
        req_y      = y;
        req_valid  = 1'b1;
        tick();
        req_valid = 1'b0;
        for (int c = 0; c < 40; c++) begin
            if (done) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({hi, lo, busy, done, timeout_err, div_start, div_signed, div_x, div_y} !== '0) begin
            errors++;
            $display("FAIL reset_outputs hi=%h lo=%h busy=%b done=%b terr=%b start=%b", hi, lo, busy, done, timeout_err, div_start);
        end
        resetn = 1'b1;
        tick();
        checks++;
        if (req_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready got %b want 1", req_ready);
        end
    endtask

    task automatic test_latency();
        bit bad_mid;
        req_signed = 1'b0;
        req_x      = 32'd100;
        req_y      = 32'd7;
        req_valid  = 1'b1;
        #1;
        checks++;
        if (req_ready !== 1'b1) begin
            errors++;
            $display("FAIL lat_accept_ready got %b want 1", req_ready);
        end
        tick();
        req_valid = 1'b0;
        checks++;
        if (div_start !== 1'b1 || busy !== 1'b1 || div_x !== 32'd100 || div_y !== 32'd7) begin
            errors++;
            $display("FAIL lat_t1 start=%b busy=%b x=%0d y=%0d want 1 1 100 7", div_start, busy, div_x, div_y);
        end
        bad_mid = 1'b0;
        for (int c = 2; c <= 12; c++) begin
            tick();
            if (div_start !== 1'b0 || busy !== 1'b1 || done !== 1'b0 || req_ready !== 1'b0) begin
                bad_mid = 1'b1;
                $display("FAIL lat_mid cycle T+%0d start=%b busy=%b done=%b ready=%b want 0 1 0 0", c, div_start, busy, done, req_ready);
            end
        end
        checks++;
        if (bad_mid) errors++;
        tick();
        checks++;
        if (done !== 1'b1 || busy !== 1'b0 || lo !== 32'd14 || hi !== 32'd2) begin
            errors++;
            $display("FAIL lat_t13 done=%b busy=%b lo=%0d hi=%0d want 1 0 14 2", done, busy, lo, hi);
        end
        tick();
        checks++;
        if (done !== 1'b0) begin
            errors++;
            $display("FAIL lat_done_pulse got %b want 0", done);
        end
    endtask

    task automatic test_signed();
        bit ok;
        run_div(1'b1, 32'hFFFF_FFF9, 32'd2, ok);
        checks++;
        if (!ok || lo !== 32'hFFFF_FFFD || hi !== 32'hFFFF_FFFF) begin
            errors++;
            $display("FAIL signed_neg_x done=%b lo=%h hi=%h want 1 fffffffd ffffffff", ok, lo, hi);
        end
        tick();
        run_div(1'b1, 32'd7, 32'hFFFF_FFFE, ok);
        checks++;
        if (!ok || lo !== 32'hFFFF_FFFD || hi !== 32'd1) begin
            errors++;
            $display("FAIL signed_neg_y done=%b lo=%h hi=%h want 1 fffffffd 00000001", ok, lo, hi);
        end
        tick();
    endtask

    task automatic test_flush();
        bit saw_done;
        bit ok;
        req_signed = 1'b0;
        req_x      = 32'h8000_0000;
        req_y      = 32'd3;
        req_valid  = 1'b1;
        tick();
        req_valid = 1'b0;
        repeat (4) tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL flush_busy got %b want 0", busy);
        end
        saw_done = 1'b0;
        for (int c = 0; c < 10; c++) begin
            if (done) saw_done = 1'b1;
            tick();
        end
        checks++;
        if (saw_done) begin
            errors++;
            $display("FAIL flush_no_done got done=1 want 0");
        end
        checks++;
        if (hi !== 32'd1 || lo !== 32'hFFFF_FFFD) begin
            errors++;
            $display("FAIL flush_hilo_kept hi=%h lo=%h want 00000001 fffffffd", hi, lo);
        end
        run_div(1'b0, 32'd9, 32'd2, ok);
        checks++;
        if (!ok || lo !== 32'd4 || hi !== 32'd1) begin
            errors++;
            $display("FAIL flush_then_div done=%b lo=%0d hi=%0d want 1 4 1", ok, lo, hi);
        end
        tick();
    endtask

    task automatic test_mt_abort();
        bit saw_done;
        req_signed = 1'b0;
        req_x      = 32'd50;
        req_y      = 32'd5;
        req_valid  = 1'b1;
        tick();
        req_valid = 1'b0;
        repeat (3) tick();
        mtlo_we = 1'b1;
        mt_data = 32'h1234_5678;
        tick();
        mtlo_we = 1'b0;
        checks++;
        if (lo !== 32'h1234_5678 || hi !== 32'd1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL mt_abort lo=%h hi=%h busy=%b want 12345678 00000001 0", lo, hi, busy);
        end
        tick();
        checks++;
        if (req_ready !== 1'b1) begin
            errors++;
            $display("FAIL mt_abort_ready got %b want 1", req_ready);
        end
        saw_done = 1'b0;
        for (int c = 0; c < 10; c++) begin
            if (done) saw_done = 1'b1;
            tick();
        end
        checks++;
        if (saw_done || lo !== 32'h1234_5678) begin
            errors++;
            $display("FAIL mt_abort_discard done_seen=%b lo=%h want 0 12345678", saw_done, lo);
        end
    endtask

    task automatic test_idle_conflicts();
        req_signed = 1'b0;
        req_x      = 32'd20;
        req_y      = 32'd4;
        req_valid  = 1'b1;
        flush      = 1'b1;
        #1;
        checks++;
        if (req_ready !== 1'b0) begin
            errors++;
            $display("FAIL idle_flush_ready got %b want 0", req_ready);
        end
        tick();
        flush   = 1'b0;
        mthi_we = 1'b1;
        mt_data = 32'hA5A5_A5A5;
        #1;
        checks++;
        if (req_ready !== 1'b0 || div_start !== 1'b0) begin
            errors++;
            $display("FAIL idle_mt_ready ready=%b start=%b want 0 0", req_ready, div_start);
        end
        tick();
        mthi_we   = 1'b0;
        req_valid = 1'b0;
        checks++;
        if (hi !== 32'hA5A5_A5A5 || div_start !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL idle_mt_write hi=%h start=%b busy=%b want a5a5a5a5 0 0", hi, div_start, busy);
        end
        tick();
    endtask

    task automatic test_timeout_and_reset();
        bit bad_wait;
        m_en = 1'b0;
        req_signed = 1'b0;
        req_x      = 32'd1;
        req_y      = 32'd1;
        req_valid  = 1'b1;
        tick();
        req_valid = 1'b0;
        bad_wait = 1'b0;
        for (int c = 2; c <= 16; c++) begin
            tick();
            if (timeout_err !== 1'b0 || busy !== 1'b1) begin
                bad_wait = 1'b1;
                $display("FAIL timeout_early cycle T+%0d terr=%b busy=%b want 0 1", c, timeout_err, busy);
            end
        end
        checks++;
        if (bad_wait) errors++;
        tick();
        checks++;
        if (timeout_err !== 1'b1 || busy !== 1'b0 || req_ready !== 1'b1 || done !== 1'b0) begin
            errors++;
            $display("FAIL timeout_set terr=%b busy=%b ready=%b done=%b want 1 0 1 0", timeout_err, busy, req_ready, done);
        end
        checks++;
        if (hi !== 32'hA5A5_A5A5 || lo !== 32'h1234_5678) begin
            errors++;
            $display("FAIL timeout_hilo hi=%h lo=%h want a5a5a5a5 12345678", hi, lo);
        end
        req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        repeat (3) tick();
        checks++;
        if (timeout_err !== 1'b1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL timeout_sticky terr=%b busy=%b want 1 1", timeout_err, busy);
        end
        resetn = 1'b0;
        #1;
        checks++;
        if ({hi, lo, busy, done, timeout_err, div_start, div_signed, div_x, div_y} !== '0) begin
            errors++;
            $display("FAIL midwait_reset hi=%h lo=%h busy=%b done=%b terr=%b x=%h", hi, lo, busy, done, timeout_err, div_x);
        end
        tick();
        resetn = 1'b1;
        m_en   = 1'b1;
        tick();
        checks++;
        if (done !== 1'b0 || busy !== 1'b0 || req_ready !== 1'b1) begin
            errors++;
            $display("FAIL post_reset done=%b busy=%b ready=%b want 0 0 1", done, busy, req_ready);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        resetn     = 1'b0;
        req_valid  = 1'b0;
        req_signed = 1'b0;
        req_x      = '0;
        req_y      = '0;
        flush      = 1'b0;
        mthi_we    = 1'b0;
        mtlo_we    = 1'b0;
        mt_data    = '0;
        m_en       = 1'b1;
        test_reset();
        test_latency();
        test_signed();
        test_flush();
        test_mt_abort();
        test_idle_conflicts();
        test_timeout_and_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/div_hilo_ctrl.md
Name: div_hilo_ctrl

Overview:
- Sequencing controller between the execute stage and the iterative divider.
- Accepts DIV/DIVU requests and issues a one-cycle start pulse to the divider.
- Tracks completion, then writes quotient to LO and remainder to HI; owns the HI/LO registers, including MTHI/MTLO writes.
- Provides busy for MFHI/MFLO interlock, and abort on pipeline flush or on a divider timeout.

Parameters:
- TIMEOUT, 16, max cycles in WAIT without div_complete before abort; must exceed the divider latency of 10 cycles from start; range 11..31.

Ports:
- clk  in  1  clock
- resetn  in  1  asynchronous active-low reset
- req_valid  in  1  execute stage presents a DIV/DIVU
- req_signed  in  1  1 = DIV, 0 = DIVU
- req_x  in  32  dividend
- req_y  in  32  divisor
- req_ready  out  1  request accepted this cycle when req_valid & req_ready
- flush  in  1  exception/flush; cancels a pending division
- mthi_we  in  1  MTHI write
- mtlo_we  in  1  MTLO write
- mt_data  in  32  MTHI/MTLO data
- hi  out  32  HI register
- lo  out  32  LO register
- busy  out  1  division in flight; MFHI/MFLO must stall
- done  out  1  one-cycle pulse: HI/LO just updated by a division
- timeout_err  out  1  sticky: divider failed to complete
- div_start  out  1  one-cycle start pulse to the divider
- div_signed  out  1  signedness to the divider
- div_x  out  32  dividend to the divider
- div_y  out  32  divisor to the divider
- div_complete  in  1  divider completion, one-cycle pulse
- div_s  in  32  divider quotient
- div_r  in  32  divider remainder

Behaviour:
- Reset values (async, resetn=0): state=IDLE, hi=0, lo=0, busy=0, done=0, timeout_err=0, div_start=0, div_signed=0, div_x=0, div_y=0, wait counter=0.
- States and transitions:
  - IDLE: req_ready = ~flush & ~mthi_we & ~mtlo_we. On accept, register req_signed/req_x/req_y into div_signed/div_x/div_y, set div_start=1, go to START.
  - START: div_start=1 for exactly this cycle; clear wait counter; go to WAIT.
  - WAIT: div_start=0; counter increments each cycle.
    - div_complete=1: go to WB.
    - Counter reaches TIMEOUT-1 without completion: set timeout_err, go to IDLE, no writeback.
  - WB: hi<=div_r, lo<=div_s, both visible next cycle; done=1 during the following cycle; go to IDLE.
- Output timing:
  - busy = 1 in START, WAIT and WB; 0 otherwise. Registered: rises the cycle after accept and falls the cycle done rises.
  - req_ready = 0 in every state other than IDLE; no queuing, single outstanding division.
- Latency with the team divider (accept in cycle T):
  - div_start high in T+1.
  - div_complete high in T+11.
  - WB in T+12.
  - hi/lo updated, done=1 and busy=0 in T+13.
  - Bench checks against div_complete, not a fixed count, except in the directed latency test.
- div_x/div_y/div_signed hold their values until the next accept; the divider latches its operands on start.
- Divisor zero: no special case; HI/LO take whatever the divider returns.
- Flush in START/WAIT/WB: go to IDLE at the next edge, no writeback, done stays 0, busy falls next cycle. A later div_complete seen in IDLE is ignored.
- Flush in the same cycle as div_complete or in WB: result discarded.
- MTHI/MTLO:
  - Always written at the next edge: hi<=mt_data on mthi_we, lo<=mt_data on mtlo_we; both may be set in the same cycle.
  - An MT write while busy also aborts the pending division exactly as flush does; the MT value is kept.
- Flush + req_valid in IDLE: not accepted. MT write + req_valid in IDLE: MT performed, request not accepted.
- A new accept restarts the divider; the previous timeout_err stays set.
- timeout_err is cleared only by reset.
- Reset mid-operation: all state cleared immediately; no done pulse.

Test Plan:
- Reset, then DIVU x=100, y=7 accepted at T -> div_start at T+1 only; done at T+13; lo=14, hi=2; busy high T+1..T+12.
- DIV x=0xFFFFFFF9 (-7), y=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIV x=7, y=0xFFFFFFFE -> lo=0xFFFFFFFD, hi=1.
- DIVU 0x80000000/3 accepted, flush at T+5 -> no done; hi/lo keep prior values; busy=0 at T+6. Then DIVU 9/2 -> lo=4, hi=1.
- Division in flight, mtlo_we=1 with mt_data=0x12345678 at T+4 -> lo=0x12345678, hi unchanged, no done, req_ready=1 at T+6.
- Same-cycle IDLE events: req_valid with flush, then req_valid with mthi_we=1, mt_data=0xA5A5A5A5 -> req_ready=0 both cycles; hi=0xA5A5A5A5; no div_start.
- Stub divider that never asserts div_complete, TIMEOUT=16 -> timeout_err=1 sixteen cycles after START; state IDLE; hi/lo unchanged. Assert resetn=0 mid-WAIT -> all outputs 0 immediately.
